// File: rtl/ei_axi4_pkg.sv
// ei_axi4_pkg: shared AXI4 channel types and arbiter state encoding
package ei_axi4_pkg;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_type_e;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} response_e;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} arb_state_e;
endpackage

// File: rtl/ei_axi4_rr_arbiter.sv
// ei_axi4_rr_arbiter: combinational round-robin pick of the first request at or after prio_ptr
module ei_axi4_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_prio_ptr,
    output logic                       o_found,
    output logic [$clog2(NUM_REQ)-1:0] o_grant
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] w_rot;
    logic [IW-1:0]      w_off;
    logic [IW:0]        w_sum;
    // rotate so bit 0 is the highest-priority requester
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_prio_ptr);
    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_rot[i]) w_off = IW'(i);
    end
    assign w_sum   = {1'b0, i_prio_ptr} + {1'b0, w_off};
    assign o_found = |w_rot;
    assign o_grant = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ)) : IW'(w_sum);
endmodule

// File: rtl/ei_axi4_wr_arbiter.sv
// ei_axi4_wr_arbiter: round-robin AXI4 write arbiter holding one grant from AW through B
module ei_axi4_wr_arbiter
    import ei_axi4_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ADDR_WIDTH-1:0]        req_awaddr  [NUM_REQ],
    input  logic [7:0]                   req_awlen   [NUM_REQ],
    input  logic [2:0]                   req_awsize  [NUM_REQ],
    input  burst_type_e                  req_awburst [NUM_REQ],
    input  logic [NUM_REQ-1:0]           req_awvalid,
    output logic [NUM_REQ-1:0]           req_awready,
    input  logic [DATA_WIDTH-1:0]        req_wdata   [NUM_REQ],
    input  logic [DATA_WIDTH/8-1:0]      req_wstrb   [NUM_REQ],
    input  logic [NUM_REQ-1:0]           req_wlast,
    input  logic [NUM_REQ-1:0]           req_wvalid,
    output logic [NUM_REQ-1:0]           req_wready,
    output response_e                    req_bresp   [NUM_REQ],
    output logic [NUM_REQ-1:0]           req_bvalid,
    input  logic [NUM_REQ-1:0]           req_bready,
    output logic [ADDR_WIDTH-1:0]        m_awaddr,
    output logic [7:0]                   m_awlen,
    output logic [2:0]                   m_awsize,
    output burst_type_e                  m_awburst,
    output logic                         m_awvalid,
    input  logic                         m_awready,
    output logic [DATA_WIDTH-1:0]        m_wdata,
    output logic [DATA_WIDTH/8-1:0]      m_wstrb,
    output logic                         m_wlast,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    input  response_e                    m_bresp,
    input  logic                         m_bvalid,
    output logic                         m_bready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         wlast_err
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_e    r_state, w_next;
    logic [IW-1:0] r_grant, r_prio, w_arb_grant;
    logic [7:0]    r_len, r_beat;
    logic          r_wlast_err, w_found, w_aw_hs, w_w_hs, w_b_hs;

    ei_axi4_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req      (req_awvalid),
        .i_prio_ptr (r_prio),
        .o_found    (w_found),
        .o_grant    (w_arb_grant)
    );

    assign m_awaddr  = req_awaddr[r_grant];
    assign m_awlen   = req_awlen[r_grant];
    assign m_awsize  = req_awsize[r_grant];
    assign m_awburst = req_awburst[r_grant];
    assign m_wdata   = req_wdata[r_grant];
    assign m_wstrb   = req_wstrb[r_grant];
    assign m_wlast   = req_wlast[r_grant];
    assign m_awvalid = (r_state == ADDR) && req_awvalid[r_grant];
    assign m_wvalid  = (r_state == DATA) && req_wvalid[r_grant];
    assign m_bready  = (r_state == RESP) && req_bready[r_grant];
    assign w_aw_hs   = m_awvalid && m_awready;
    assign w_w_hs    = m_wvalid && m_wready;
    assign w_b_hs    = m_bvalid && m_bready;
    assign grant_id  = r_grant;
    assign busy      = (r_state != IDLE);
    assign wlast_err = r_wlast_err;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_awready[i] = (r_grant == IW'(i)) && (r_state == ADDR) && m_awready;
            req_wready[i]  = (r_grant == IW'(i)) && (r_state == DATA) && m_wready;
            req_bvalid[i]  = (r_grant == IW'(i)) && (r_state == RESP) && m_bvalid;
            req_bresp[i]   = (r_grant == IW'(i)) ? m_bresp : OKAY;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_found ? ADDR : IDLE;
            ADDR:    w_next = w_aw_hs ? DATA : ADDR;
            DATA:    w_next = (w_w_hs && m_wlast) ? RESP : DATA;
            default: w_next = w_b_hs ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge aclk or posedge areset)
        if (areset) r_state <= IDLE;
        else        r_state <= w_next;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_grant     <= '0;
            r_prio      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_wlast_err <= 1'b0;
        end else begin
            if (r_state == IDLE && w_found) r_grant <= w_arb_grant;
            if (w_aw_hs) begin
                r_len  <= m_awlen;
                r_beat <= '0;
            end
            if (w_w_hs) r_beat <= r_beat + 8'd1;
            if (w_b_hs) r_prio <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
            // flag a wlast that disagrees with awlen; the FSM still follows wlast
            r_wlast_err <= w_w_hs && (m_wlast != (r_beat == r_len));
        end
    end
endmodule

// File: doc/ei_axi4_wr_arbiter.md
# ei_axi4_wr_arbiter

Round-robin arbiter that lets NUM_REQ AXI4 write requesters share one downstream AXI4 slave write port (AW, W, B channels). It grants one requester at a time, holds the grant from address acceptance through the last data beat and the write response, and then rotates priority. It sits between the master-side VIP agents or fabric ports and the slave interface, and only sequences and routes the channels; it does not buffer data.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, `ADDR_WIDTH, address width
- DATA_WIDTH, `DATA_WIDTH, data width; STRB_WIDTH = DATA_WIDTH/8
- aclk  in  1  clock; all logic on posedge
- areset  in  1  asynchronous, active-high reset
- req_awaddr / req_awlen / req_awsize / req_awburst  in  NUM_REQ x (ADDR_WIDTH / 8 / 3 / burst_type_e)  per-requester AW payload
- req_awvalid  in  NUM_REQ  per-requester AW valid
- req_awready  out  NUM_REQ  per-requester AW ready
- req_wdata / req_wstrb / req_wlast  in  NUM_REQ x (DATA_WIDTH / STRB_WIDTH / 1)  per-requester W payload
- req_wvalid  in  NUM_REQ;  req_wready  out  NUM_REQ
- req_bresp  out  NUM_REQ x response_e;  req_bvalid  out  NUM_REQ;  req_bready  in  NUM_REQ
- m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid  out;  m_awready  in
- m_wdata, m_wstrb, m_wlast, m_wvalid  out;  m_wready  in
- m_bresp, m_bvalid  in;  m_bready  out
- grant_id  out  $clog2(NUM_REQ)  currently granted requester (valid when busy=1)
- busy  out  1  high in any state other than IDLE
- wlast_err  out  1  one-cycle pulse on a WLAST/AWLEN mismatch

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any req_awvalid is high, pick the first asserted requester at or after prio_ptr, wrapping around. Register its index in grant_id and go to ADDR. With no requests, stay in IDLE.
- ADDR: forward AW payload and valid from grant_id to m_aw*, and m_awready to req_awready[grant_id]. On the m_awvalid && m_awready handshake, capture awlen into len_q, clear beat_cnt, and go to DATA.
- DATA: forward the W channel of grant_id and route m_wready back to it. Each accepted beat increments beat_cnt (8-bit). On an accepted beat with wlast=1, go to RESP.
- RESP: forward m_bresp and m_bvalid to req_b*[grant_id], and req_bready[grant_id] to m_bready. On the handshake, set prio_ptr = (grant_id+1) mod NUM_REQ and go to IDLE.
- Non-granted requesters see req_awready, req_wready and req_bvalid at 0. req_bresp for a non-granted requester is OKAY.
- m_* valids are 0 outside their own state. Payload outputs are don't-care but driven from the granted requester.
- wlast_err pulses in either case:
  - an accepted beat with wlast=1 while beat_cnt != len_q;
  - an accepted beat with beat_cnt == len_q and wlast=0.
- The FSM still advances only on the observed wlast; it is never forced.
- W beats presented by the granted requester before AW is accepted are not forwarded; req_wready stays 0 in ADDR.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, prio_ptr=0, grant_id=0, len_q=0, beat_cnt=0, busy=0, wlast_err=0. All ready and valid outputs are 0 while reset is asserted and in the first cycle after release.
- Arbitration is registered: a request seen in IDLE at edge N drives m_awvalid from edge N+1.
- Forwarding in ADDR, DATA and RESP is combinational with zero added latency. Each channel supports back-to-back beats at 1 beat/cycle.
- Minimum transaction with awlen=0 and all readies high: 4 cycles (IDLE, ADDR, DATA, RESP). The next grant is decided in the following IDLE cycle.
- Simultaneous requests: rotating priority, so each requester is granted within NUM_REQ transactions.
- A requester dropping awvalid in ADDR before the handshake is a protocol violation. Behaviour is undefined; no recovery is required.
- Reset mid-transaction aborts to IDLE immediately. In-flight beats are lost.

## Structure
- ei_axi4_pkg holds burst_type_e, response_e (existing), and the new arb_state_e {IDLE, ADDR, DATA, RESP}.
- Sub-module ei_axi4_rr_arbiter (NUM_REQ): inputs req vector and prio_ptr; outputs found and grant index. Purely combinational, reused later for the read arbiter.

## Test plan
- Single requester 0, awlen=3, all readies high -> 4 W beats forwarded, B=OKAY returned to req 0 only, busy high for 6 cycles, wlast_err never set.
- Requesters 0 and 1 both raise awvalid in IDLE after reset -> grant order 0,1,0,1 over four back-to-back transactions; req_awready[1] stays 0 during req 0's burst.
- m_wready toggled 1,0,1,0 during an 8-beat burst -> exactly 8 beats on m_w*, beat_cnt=7 at wlast, no duplicated or dropped beat.
- awlen=3 with wlast asserted on beat 2 -> wlast_err pulses once and the FSM goes to RESP.
- areset asserted in DATA after 2 of 4 beats -> all readies and valids drop that cycle; after release state=IDLE, prio_ptr=0, and a new request is granted normally.
- m_bvalid held high with req_bready low for 5 cycles -> m_bready stays low, the FSM remains in RESP, and there is no new grant until the handshake.
